interval_timer: RTL and testbench
=================================

// Module: interval_timer
// PURPOSE
// - Parametrised programmable tick generator; successor to the fixed-count alarm-clock timer.
// - Runtime-loadable period, periodic or one-shot mode, start/stop/pause control, done flag, live count.
// - Drives clock-domain timing events: 1 ms base tick, seconds, alarm/snooze countdowns.
// PARAMETERS
// - WIDTH           27       counter/period width in bits
// - DEFAULT_PERIOD  125_000  period_q value after reset; must fit in WIDTH bits
// - AUTO_START      1        1: state after reset is RUN in periodic mode; 0: state after reset is IDLE
// PORTS
// - clk          in   1      single clock; all state updates on posedge
// - reset        in   1      asynchronous, active-high reset
// - start        in   1      pulse: (re)start counting from 0
// - stop         in   1      pulse: abort, go IDLE, clear count
// - en           in   1      count enable; low in RUN = pause (count held, no tick)
// - mode         in   1      0 periodic, 1 one-shot; sampled only when start is accepted
// - load_period  in   1      pulse: capture period_in into the shadow register
// - period_in    in   WIDTH  new period P; tick spacing is P+1 enabled cycles
// - tick         out  1      one-cycle tick pulse
// - done         out  1      one-shot finished; held until start or stop
// - busy         out  1      state == RUN
// - count        out  WIDTH  current counter value
// BEHAVIOUR
// - Reset (async): count=0, period_q=shadow=DEFAULT_PERIOD, pend=0, tick=0, done=0.
// - Reset, AUTO_START=1: state=RUN, mode_q=periodic, busy=1. Reset, AUTO_START=0: state=IDLE, busy=0.
// - States: IDLE, RUN, DONE. busy=(RUN). done=(DONE).
// - tick = RUN && en && (count == period_q). Combinational from registers; no input-to-output paths except en.
// - RUN, en=1, count<period_q: count <= count+1.
// - RUN, en=1, count==period_q, periodic: count <= 0.
//   If pend: period_q <= shadow, pend <= 0.
// - RUN, en=1, count==period_q, one-shot: state <= DONE. count is held at period_q.
// - RUN, en=0: count, period_q and state are held.
// - start accepted in any state: state <= RUN, count <= 0, mode_q <= mode, done clears.
//   If pend (or load in the same cycle): period_q <= new value.
// - Timing: start accepted at edge k with en=1 gives the first tick in cycle k+P. Tick spacing is P+1 cycles.
// - stop: state <= IDLE, count <= 0. stop has priority over start in the same cycle.
// - load_period: shadow <= period_in, pend <= 1.
//   In IDLE or DONE with no start, period_q is also updated immediately and pend stays 0.
//   In RUN, the new period applies only at the next wrap or start; it never truncates the current interval.
// - load and wrap in the same cycle: the just-loaded value is applied at that wrap.
// - P=0: tick every enabled cycle. P=2^WIDTH-1: count reaches all-ones and returns to 0; there is no overflow path.
// - IDLE and DONE: count holds (0 in IDLE), tick=0, en is ignored.
// - Priority: reset > stop > start > wrap/increment; load_period is independent of these.
// TESTING
// - Reset, AUTO_START=1, DEFAULT_PERIOD=4, en=1: tick in cycles 4, 9, 14; count sequence 0..4,0.
// - Reset, AUTO_START=0: busy=0, count=0, no tick for 20 cycles even with en=1.
// - load 2, start one-shot: tick once 2 cycles after the start edge. Then done=1, busy=0, count=2 held.
//   A new start clears done.
// - Periodic P=9: load 3 when count=5 -> ticks at count 9, then every 4 cycles (no truncated interval).
// - Periodic P=4: en low 3 cycles mid-interval -> count frozen, next tick delayed exactly 3 cycles.
// - Periodic P=4: start+stop in the same cycle -> IDLE, count=0.
//   Assert reset at count=3 -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/interval_timer.sv
// interval_timer: programmable tick generator with periodic/one-shot modes, pause and shadowed period reload.
module interval_timer #(
  parameter int WIDTH          = 27,
  parameter int DEFAULT_PERIOD = 125_000,
  parameter bit AUTO_START     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  input  logic             load_period,
  input  logic [WIDTH-1:0] period_in,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] count_n, period_q, period_n, shadow;
  logic pend, pend_n, mode_q, mode_n, go, reload;
  assign go     = start && !stop;
  assign tick   = (state == RUN) && en && (count == period_q);
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign reload = load_period || pend;
  always_comb begin
    state_n  = state;
    count_n  = count;
    period_n = period_q;
    pend_n   = pend;
    mode_n   = mode_q;
    if (load_period) begin
      pend_n = 1'b1;
      if (state != RUN && !go) begin
        period_n = period_in;
        pend_n   = 1'b0;
      end
    end
    if (stop) begin
      state_n = IDLE;
      count_n = '0;
    end else if (start) begin
      state_n = RUN;
      count_n = '0;
      mode_n  = mode;
      if (reload) begin
        period_n = load_period ? period_in : shadow;
        pend_n   = 1'b0;
      end
    end else if (tick) begin
      if (mode_q) state_n = DONE;
      else begin
        count_n = '0;
        // a period loaded on the wrap cycle itself takes effect right here
        if (reload) begin
          period_n = load_period ? period_in : shadow;
          pend_n   = 1'b0;
        end
      end
    end else if (state == RUN && en) begin
      count_n = count + WIDTH'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= AUTO_START ? RUN : IDLE;
      count    <= '0;
      period_q <= WIDTH'(DEFAULT_PERIOD);
      shadow   <= WIDTH'(DEFAULT_PERIOD);
      pend     <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      period_q <= period_n;
      pend     <= pend_n;
      mode_q   <= mode_n;
      if (load_period) shadow <= period_in;
    end
  end
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed stimulus with a tick scoreboard (expected cycle and count per tick).
module tb_interval_timer;
  localparam int W = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, en = 1'b1, mode = 1'b0, load_period = 1'b0;
  logic [W-1:0] period_in = '0;
  logic tick, done, busy, tick_b, done_b, busy_b;
  logic [W-1:0] count, count_b;
  int cyc, checks, errors, ticks_b, k;
  typedef struct {int c; int p;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  interval_timer #(.WIDTH(W), .DEFAULT_PERIOD(4), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .mode(mode),
    .load_period(load_period), .period_in(period_in),
    .tick(tick), .done(done), .busy(busy), .count(count));

  interval_timer #(.WIDTH(W), .DEFAULT_PERIOD(4), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(1'b0), .stop(1'b0), .en(1'b1), .mode(1'b0),
    .load_period(1'b0), .period_in('0),
    .tick(tick_b), .done(done_b), .busy(busy_b), .count(count_b));

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  // monitor: every tick must match the oldest expected (cycle, count)
  always @(negedge clk) begin
    if (!reset) begin
      if (tick_b) ticks_b++;
      if (tick) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick cyc=%0d count=%0d", cyc, count);
        end else begin
          e = q.pop_front();
          if (e.c != cyc || e.p != int'(count)) begin
            errors++;
            $display("FAIL tick got cyc=%0d count=%0d want cyc=%0d count=%0d", cyc, count, e.c, e.p);
          end
        end
      end
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int p);
    q.push_back('{c, p});
  endtask

  task automatic do_load(input int p);
    load_period = 1'b1;
    period_in   = W'(p);
    step(1);
    load_period = 1'b0;
  endtask

  task automatic do_start(input logic md);
    start = 1'b1;
    mode  = md;
    step(1);
    start = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_count", count_b, 0);
    push(4, 4); push(9, 4); push(14, 4); push(19, 4);
    for (int i = 0; i < 6; i++) begin
      chk("count_seq", count, i % 5);
      step(1);
    end
    step(15);
    chk("b_no_tick", ticks_b, 0);
    chk("b_count_idle", count_b, 0);
    do_stop();
    chk("stop_busy", busy, 0);
    chk("stop_count", count, 0);
    // one-shot P=2
    do_load(2);
    k = cyc + 1;
    push(k + 2, 2);
    do_start(1'b1);
    step(3);
    chk("os_done", done, 1);
    chk("os_busy", busy, 0);
    chk("os_count", count, 2);
    step(4);
    chk("os_done_held", done, 1);
    chk("os_count_held", count, 2);
    // restart periodic with load 9 in the same cycle, then reload 3 mid-interval
    load_period = 1'b1;
    period_in   = W'(9);
    k = cyc + 1;
    push(k + 9, 9); push(k + 13, 3); push(k + 17, 3);
    do_start(1'b0);
    load_period = 1'b0;
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_count", count, 0);
    step(5);
    chk("count_at_load", count, 5);
    do_load(3);
    step(12);
    do_stop();
    chk("stop2_count", count, 0);
    // pause for 3 cycles, then load on a wrap cycle
    do_load(4);
    k = cyc + 1;
    push(k + 4, 4); push(k + 12, 4); push(k + 14, 1); push(k + 16, 1);
    do_start(1'b0);
    step(6);
    en = 1'b0;
    chk("pause_c0", count, 1);
    step(1);
    chk("pause_c1", count, 1);
    chk("pause_no_tick", tick, 0);
    step(1);
    chk("pause_c2", count, 1);
    step(1);
    en = 1'b1;
    chk("pause_c3", count, 1);
    step(3);
    chk("wrap_load_count", count, 4);
    do_load(1);
    step(4);
    do_stop();
    // P=0: tick every cycle
    do_load(0);
    k = cyc + 1;
    push(k, 0); push(k + 1, 0); push(k + 2, 0);
    do_start(1'b0);
    step(2);
    do_stop();
    // P=all-ones wraps to 0
    do_load(255);
    k = cyc + 1;
    push(k + 255, 255); push(k + 511, 255);
    do_start(1'b0);
    step(256);
    chk("allones_wrap", count, 0);
    step(256);
    do_stop();
    // start+stop together, then async reset mid-count
    do_load(4);
    do_start(1'b0);
    step(2);
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_count", count, 0);
    do_start(1'b0);
    step(3);
    chk("pre_reset_count", count, 3);
    #2 reset = 1'b1;
    #1;
    chk("areset_count", count, 0);
    chk("areset_busy", busy, 1);
    chk("areset_done", done, 0);
    chk("areset_tick", tick, 0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
